board_move_unit: RTL and testbench

BOARD_MOVE_UNIT -- requirements
Module: board_move_unit

---
 rtl/board_pkg.sv | 25 ++
 rtl/board_move_unit_if.sv | 31 +++
 rtl/board_nbr.sv | 47 ++++
 rtl/board_move_unit.sv | 141 ++++++++++++++
 tb/tb_board_move_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared constants for the sliding-tile board move unit.
// Opcodes, FSM encoding and the index-width helper.
package board_pkg;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_UP    = 3'd1;
    localparam logic [2:0] OP_DOWN  = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_RIGHT = 3'd4;
    localparam logic [2:0] OP_COMP  = 3'd5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic int pw_of(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/board_move_unit_if.sv
// Command and status bundle of the board move unit.
// The master issues commands; the slave owns the board.
interface board_move_unit_if #(
    parameter int SIDE = 3,
    parameter int TW   = 4
);
    localparam int N  = SIDE * SIDE;
    localparam int PW = board_pkg::pw_of(N);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [N*TW-1:0] load_board;
    logic [N*TW-1:0] goal_board;
    logic [N*TW-1:0] board;
    logic [PW-1:0]   blank_pos;
    logic            done;
    logic            err;
    logic            zf;

    modport master (
        output cmd_valid, cmd_op, load_board, goal_board,
        input  cmd_ready, board, blank_pos, done, err, zf
    );

    modport slave (
        input  cmd_valid, cmd_op, load_board, goal_board,
        output cmd_ready, board, blank_pos, done, err, zf
    );

endinterface

// File: rtl/board_nbr.sv
// Neighbour cell and edge legality for a blank move.
// Purely combinational.
module board_nbr #(
    parameter int SIDE = 3,
    parameter int PW   = board_pkg::pw_of(SIDE * SIDE)
) (
    input  logic [PW-1:0] pos,
    input  logic [2:0]    dir,
    output logic [PW-1:0] nbr_pos,
    output logic          legal
);
    import board_pkg::*;

    int p;
    int row;
    int col;
    int nbr;

    always_comb begin
        p     = int'(pos);
        row   = p / SIDE;
        col   = p % SIDE;
        nbr   = p;
        legal = 1'b0;
        unique case (1'b1)
            (dir == OP_UP): begin
                legal = (row > 0);
                nbr   = p - SIDE;
            end
            (dir == OP_DOWN): begin
                legal = (row < SIDE - 1);
                nbr   = p + SIDE;
            end
            (dir == OP_LEFT): begin
                legal = (col > 0);
                nbr   = p - 1;
            end
            (dir == OP_RIGHT): begin
                legal = (col < SIDE - 1);
                nbr   = p + 1;
            end
            default: ;
        endcase
        nbr_pos = PW'(nbr);
    end

endmodule

// File: rtl/board_move_unit.sv
// Sliding-tile board: load with blank scan, blank moves,
// and cell-serial compare against a goal image.
module board_move_unit #(
    parameter int SIDE = 3,
    parameter int TW   = 4
) (
    input logic              clk,
    input logic              rst_n,
    board_move_unit_if.slave bus
);
    import board_pkg::*;

    localparam int N  = SIDE * SIDE;
    localparam int PW = pw_of(N);

    logic [2:0]    state;
    logic [2:0]    op;
    logic [PW-1:0] idx;
    logic [PW-1:0] bpos;
    logic [TW-1:0] cells [N];
    logic [TW-1:0] goal  [N];
    logic          bvalid;
    logic          zf_q;
    logic          err_q;
    logic          done_q;
    logic [PW-1:0] nbr_pos;
    logic          legal;
    logic          legal_mv;

    board_nbr #(
        .SIDE (SIDE),
        .PW   (PW)
    ) u_nbr (
        .pos     (bpos),
        .dir     (op),
        .nbr_pos (nbr_pos),
        .legal   (legal)
    );

    // Without a known blank no move may touch the board.
    assign legal_mv = legal & bvalid;

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.blank_pos = bpos;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.zf        = zf_q;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.board[g*TW +: TW] = cells[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op     <= OP_LOAD;
            idx    <= '0;
            bpos   <= '0;
            bvalid <= 1'b0;
            zf_q   <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cells[i] <= '0;
                goal[i]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        err_q <= 1'b0;
                        op    <= bus.cmd_op;
                        unique case (1'b1)
                            (bus.cmd_op == OP_LOAD): begin
                                for (int i = 0; i < N; i++)
                                    cells[i] <= bus.load_board[i*TW +: TW];
                                idx   <= '0;
                                state <= S_SCAN;
                            end
                            (bus.cmd_op inside
                                {OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT}): begin
                                state <= S_EXEC;
                            end
                            (bus.cmd_op == OP_COMP): begin
                                for (int i = 0; i < N; i++)
                                    goal[i] <= bus.goal_board[i*TW +: TW];
                                idx   <= '0;
                                state <= S_CMP;
                            end
                            default: begin
                                err_q <= 1'b1;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_SCAN: begin
                    if (cells[idx] == '0) begin
                        bpos   <= idx;
                        bvalid <= 1'b1;
                        state  <= S_DONE;
                    end else if (idx == PW'(N - 1)) begin
                        bvalid <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (legal_mv) begin
                        cells[bpos]    <= cells[nbr_pos];
                        cells[nbr_pos] <= '0;
                        bpos           <= nbr_pos;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state <= S_DONE;
                end
                S_CMP: begin
                    if (cells[idx] != goal[idx]) begin
                        zf_q  <= 1'b0;
                        state <= S_DONE;
                    end else if (idx == PW'(N - 1)) begin
                        zf_q  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_unit.sv
// Directed vector bench for board_move_unit (3x3 and 4x4).
module tb_board_move_unit;
    import board_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    board_move_unit_if #(.SIDE(3), .TW(4)) b3 ();
    board_move_unit_if #(.SIDE(4), .TW(4)) b4 ();

    board_move_unit #(.SIDE(3), .TW(4)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    board_move_unit #(.SIDE(4), .TW(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [35:0] B0   = 36'h0_8765_4321;
    localparam logic [35:0] B1   = 36'h6_8705_4321;
    localparam logic [35:0] G2   = 36'h0_8765_4322;
    localparam logic [35:0] ONES = 36'h1_1111_1111;
    localparam logic [63:0] C16  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] C16M = 64'hFEDC_BA98_7604_3251;

    typedef struct {
        logic [2:0]  op;
        logic [35:0] ld;
        logic [35:0] gl;
        int          lat;
        logic        er;
        logic        z;
        logic [3:0]  bp;
        logic [35:0] brd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run3(input vec_t v, input int r);
        int lat;
        @(negedge clk);
        chk($sformatf("r%0d ready", r), 64'(b3.cmd_ready), 64'd1);
        b3.cmd_valid  = 1'b1;
        b3.cmd_op     = v.op;
        b3.load_board = v.ld;
        b3.goal_board = v.gl;
        @(posedge clk);
        #1;
        b3.cmd_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b3.done) break;
        end
        chk($sformatf("r%0d latency", r), 64'(lat), 64'(v.lat));
        chk($sformatf("r%0d err", r), 64'(b3.err), 64'(v.er));
        chk($sformatf("r%0d zf", r), 64'(b3.zf), 64'(v.z));
        chk($sformatf("r%0d blank", r), 64'(b3.blank_pos), 64'(v.bp));
        chk($sformatf("r%0d board", r), 64'(b3.board), 64'(v.brd));
        @(posedge clk);
        #1;
        chk($sformatf("r%0d done pulse", r), 64'(b3.done), 64'd0);
    endtask

    task automatic run4(input logic [2:0] op, input logic [63:0] ld,
                        input int elat, input logic eerr,
                        input logic [3:0] ebp, input string nm);
        int lat;
        @(negedge clk);
        b4.cmd_valid  = 1'b1;
        b4.cmd_op     = op;
        b4.load_board = ld;
        b4.goal_board = '0;
        @(posedge clk);
        #1;
        b4.cmd_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b4.done) break;
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " err"}, 64'(b4.err), 64'(eerr));
        chk({nm, " blank"}, 64'(b4.blank_pos), 64'(ebp));
    endtask

    initial begin
        int lat;
        int dcnt;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        b3.cmd_valid  = 1'b0;
        b3.cmd_op     = OP_LOAD;
        b3.load_board = '0;
        b3.goal_board = '0;
        b4.cmd_valid  = 1'b0;
        b4.cmd_op     = OP_LOAD;
        b4.load_board = '0;
        b4.goal_board = '0;

        tbl[0]  = '{OP_LOAD,  B0,   '0, 10, 1'b0, 1'b0, 4'd8, B0};
        tbl[1]  = '{OP_RIGHT, '0,   '0, 2,  1'b1, 1'b0, 4'd8, B0};
        tbl[2]  = '{OP_DOWN,  '0,   '0, 2,  1'b1, 1'b0, 4'd8, B0};
        tbl[3]  = '{OP_UP,    '0,   '0, 2,  1'b0, 1'b0, 4'd5, B1};
        tbl[4]  = '{OP_DOWN,  '0,   '0, 2,  1'b0, 1'b0, 4'd8, B0};
        tbl[5]  = '{OP_COMP,  '0,   B0, 10, 1'b0, 1'b1, 4'd8, B0};
        tbl[6]  = '{OP_COMP,  '0,   G2, 2,  1'b0, 1'b0, 4'd8, B0};
        tbl[7]  = '{OP_LOAD,  ONES, '0, 10, 1'b1, 1'b0, 4'd8, ONES};
        tbl[8]  = '{OP_UP,    '0,   '0, 2,  1'b1, 1'b0, 4'd8, ONES};
        tbl[9]  = '{3'd6,     '0,   '0, 1,  1'b1, 1'b0, 4'd8, ONES};
        tbl[10] = '{3'd7,     '0,   '0, 1,  1'b1, 1'b0, 4'd8, ONES};

        repeat (2) @(posedge clk);
        #1;
        chk("rst board", 64'(b3.board), 64'd0);
        chk("rst blank", 64'(b3.blank_pos), 64'd0);
        chk("rst done", 64'(b3.done), 64'd0);
        chk("rst err", 64'(b3.err), 64'd0);
        chk("rst zf", 64'(b3.zf), 64'd0);
        chk("rst ready", 64'(b3.cmd_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 11; r++) run3(tbl[r], r);

        // Commands offered while busy must be dropped.
        @(negedge clk);
        b3.cmd_valid  = 1'b1;
        b3.cmd_op     = OP_LOAD;
        b3.load_board = B0;
        @(posedge clk);
        #1;
        b3.cmd_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            b3.cmd_valid = (lat >= 1 && lat <= 3);
            b3.cmd_op    = OP_UP;
            if (b3.done) break;
        end
        b3.cmd_valid = 1'b0;
        chk("busy latency", 64'(lat), 64'd10);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (b3.done) dcnt++;
        end
        chk("busy no extra done", 64'(dcnt), 64'd0);
        chk("busy blank", 64'(b3.blank_pos), 64'd8);
        chk("busy board", 64'(b3.board), 64'(B0));

        // Reset while the scan sits on cell 4.
        @(negedge clk);
        b3.cmd_valid  = 1'b1;
        b3.cmd_op     = OP_LOAD;
        b3.load_board = B0;
        @(posedge clk);
        #1;
        b3.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst board", 64'(b3.board), 64'd0);
        chk("mid rst blank", 64'(b3.blank_pos), 64'd0);
        chk("mid rst err", 64'(b3.err), 64'd0);
        chk("mid rst zf", 64'(b3.zf), 64'd0);
        chk("mid rst done", 64'(b3.done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst ready", 64'(b3.cmd_ready), 64'd1);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (b3.done) dcnt++;
        end
        chk("post rst no done", 64'(dcnt), 64'd0);

        run4(OP_LOAD,  C16, 2, 1'b0, 4'd0, "s4 load");
        run4(OP_LEFT,  '0,  2, 1'b1, 4'd0, "s4 left");
        run4(OP_UP,    '0,  2, 1'b1, 4'd0, "s4 up");
        run4(OP_RIGHT, '0,  2, 1'b0, 4'd1, "s4 right");
        run4(OP_DOWN,  '0,  2, 1'b0, 4'd5, "s4 down");
        chk("s4 board", b4.board, C16M);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
